latch_writer: RTL and testbench

//  Write-side controller for a bank of level-sensitive latches with reset.

---
 rtl/latch_writer.sv | 165 ++++++++++++++++
 tb/tb_latch_writer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/latch_writer.sv
// Write/clear sequencer for a transparent-latch bank: setup/pulse/hold timing, then readback check.
// Write takes SETUP+PULSE+HOLD+1 cycles to done, clear PULSE+HOLD+1; wr_ready_o is low while busy and requests are dropped.
module latch_writer #(
  parameter int WIDTH     = 8,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_valid_i,
  output logic             wr_ready_o,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             clr_req_i,
  output logic [WIDTH-1:0] lat_d_o,
  output logic             lat_en_o,
  output logic             lat_clr_o,
  input  logic [WIDTH-1:0] lat_q_i,
  output logic             done_o,
  output logic             err_o
);

  localparam int MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_LEN = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
  localparam int CW      = $clog2(MAX_LEN) + 1;

  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_PULSE = 3'd2,
    S_HOLD  = 3'd3,
    S_CHECK = 3'd4
  } state_e;

  typedef enum logic {
    M_WR  = 1'b0,
    M_CLR = 1'b1
  } mode_e;

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [WIDTH-1:0] lat_d_q, lat_d_d;
  logic             lat_en_q, lat_en_d;
  logic             lat_clr_q, lat_clr_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             ready_q, ready_d;
  logic             cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    lat_d_d = lat_d_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Clear wins over write; lat_d keeps its old value during a clear.
        if (clr_req_i) begin
          mode_d  = M_CLR;
          exp_d   = '0;
          cnt_d   = PULSE_LD;
          state_d = S_PULSE;
        end else if (wr_valid_i) begin
          mode_d  = M_WR;
          exp_d   = wr_data_i;
          lat_d_d = wr_data_i;
          cnt_d   = SETUP_LD;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_zero) begin
          cnt_d   = PULSE_LD;
          state_d = S_PULSE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_PULSE: begin
        if (cnt_zero) begin
          cnt_d   = HOLD_LD;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_HOLD: begin
        if (cnt_zero) begin
          cnt_d   = '0;
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_CHECK: begin
        done_d  = 1'b1;
        err_d   = (lat_q_i != exp_q);
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Pulse outputs are decoded from the next state so they are registered yet aligned with it.
  always_comb begin
    ready_d   = (state_d == S_IDLE);
    lat_en_d  = (state_d == S_PULSE) && (mode_d == M_WR);
    lat_clr_d = (state_d == S_PULSE) && (mode_d == M_CLR);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      mode_q    <= M_WR;
      cnt_q     <= '0;
      exp_q     <= '0;
      lat_d_q   <= '0;
      lat_en_q  <= 1'b0;
      lat_clr_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      cnt_q     <= cnt_d;
      exp_q     <= exp_d;
      lat_d_q   <= lat_d_d;
      lat_en_q  <= lat_en_d;
      lat_clr_q <= lat_clr_d;
      done_q    <= done_d;
      err_q     <= err_d;
      ready_q   <= ready_d;
    end
  end

  assign wr_ready_o = ready_q;
  assign lat_d_o    = lat_d_q;
  assign lat_en_o   = lat_en_q;
  assign lat_clr_o  = lat_clr_q;
  assign done_o     = done_q;
  assign err_o      = err_q;

  a_en_clr_exclusive: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(lat_en_q && lat_clr_q));
  a_d_stable_in_pulse: assert property (@(posedge clk_i) disable iff (!rst_ni)
    lat_en_q |=> $stable(lat_d_q));

endmodule

// File: tb/tb_latch_writer.sv
// Scoreboarded bench for latch_writer: a latch-bank model drives lat_q, a monitor checks done/err/timing.
module tb_latch_writer;

  localparam int W  = 8;
  localparam int SC = 1;
  localparam int PC = 2;
  localparam int HC = 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         wr_valid;
  logic         wr_ready;
  logic [W-1:0] wr_data;
  logic         clr_req;
  logic [W-1:0] lat_d;
  logic         lat_en;
  logic         lat_clr;
  logic [W-1:0] lat_q;
  logic         done;
  logic         err;

  always #5 clk = ~clk;

  latch_writer #(.WIDTH(W), .SETUP_CYC(SC), .PULSE_CYC(PC), .HOLD_CYC(HC)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .wr_valid_i (wr_valid),
    .wr_ready_o (wr_ready),
    .wr_data_i  (wr_data),
    .clr_req_i  (clr_req),
    .lat_d_o    (lat_d),
    .lat_en_o   (lat_en),
    .lat_clr_o  (lat_clr),
    .lat_q_i    (lat_q),
    .done_o     (done),
    .err_o      (err)
  );

  // Behavioural latch bank with optional readback faults.
  logic [W-1:0] latch_val = '0;
  logic         stuck = 1'b0;
  logic [W-1:0] corrupt = '0;
  always @(lat_en or lat_clr or lat_d) begin
    if (lat_clr) latch_val = '0;
    else if (lat_en) latch_val = lat_d;
  end
  assign lat_q = stuck ? '0 : (latch_val ^ corrupt);

  typedef struct {
    bit           is_clr;
    logic [W-1:0] data;
    bit           err;
    int           done_cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_done_cyc = -1;
  logic last_err = 1'b0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Reference: the latch ends up holding the requested value; readback passes through the fault model.
  function automatic bit model_err(input bit is_clr, input logic [W-1:0] data);
    logic [W-1:0] want;
    logic [W-1:0] seen;
    want = is_clr ? '0 : data;
    seen = stuck ? '0 : (want ^ corrupt);
    return seen != want;
  endfunction

  function automatic int model_lat(input bit is_clr);
    return is_clr ? (PC + HC + 1) : (SC + PC + HC + 1);
  endfunction

  // Monitor
  logic         prev_en = 1'b0;
  logic         prev_clr = 1'b0;
  logic [W-1:0] prev_d;
  int           en_run = 0;
  int           clr_run = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n || !mon_en) begin
      en_run  = 0;
      clr_run = 0;
    end else begin
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = q.pop_front();
          chk("done_cycle", cyc, e.done_cyc);
          chk("err", 32'(err), 32'(e.err));
        end
        last_done_cyc = cyc;
        last_err      = err;
      end else begin
        chk("err_without_done", 32'(err), 32'd0);
      end
      chk("ready", 32'(wr_ready), 32'(q.size() == 0));
      chk("en_clr_overlap", 32'(lat_en & lat_clr), 32'd0);
      if (lat_en) begin
        chk("lat_d_stable_en", lat_d, prev_d);
        if (en_run == 0 && q.size() > 0) begin
          chk("lat_d_value", lat_d, q[0].data);
          chk("en_during_clear", 32'(q[0].is_clr), 32'd0);
        end
        en_run++;
      end else if (en_run > 0) begin
        chk("en_width", en_run, PC);
        chk("lat_d_hold", lat_d, prev_d);
        en_run = 0;
      end
      if (lat_clr) begin
        chk("lat_d_stable_clr", lat_d, prev_d);
        if (clr_run == 0 && q.size() > 0) chk("clr_during_write", 32'(q[0].is_clr), 32'd1);
        clr_run++;
      end else if (clr_run > 0) begin
        chk("clr_width", clr_run, PC);
        clr_run = 0;
      end
    end
    prev_en  = lat_en;
    prev_clr = lat_clr;
    prev_d   = lat_d;
  end

  // Presents a request once the DUT is ready; optional wr_valid noise while it is busy.
  task automatic issue(input bit is_clr, input logic [W-1:0] data, input bit also_valid,
                       input bit noise, output int acc);
    exp_t e;
    int   t;
    t = 0;
    @(negedge clk);
    while (!wr_ready && t < 50) begin
      if (noise) begin
        wr_valid = 1'($urandom_range(0, 1));
        wr_data  = W'($urandom);
      end
      @(negedge clk);
      t++;
    end
    if (!wr_ready) begin
      chk("ready_timeout", 32'(wr_ready), 32'd1);
      wr_valid = 1'b0;
      acc = -1;
      return;
    end
    clr_req  = is_clr;
    wr_valid = !is_clr || also_valid;
    wr_data  = data;
    @(posedge clk);
    #1;
    acc        = cyc;
    e.is_clr   = is_clr;
    e.data     = data;
    e.err      = model_err(is_clr, data);
    e.done_cyc = acc + model_lat(is_clr);
    q.push_back(e);
    clr_req  = 1'b0;
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) begin
      chk("idle_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc;
    int acc2;
    int t;
    rst_n    = 1'b0;
    wr_valid = 1'b1;
    wr_data  = 8'h77;
    clr_req  = 1'b0;

    // Reset held three edges with a pending write
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_ready", 32'(wr_ready), 32'd1);
      chk("rst_en", 32'(lat_en), 32'd0);
      chk("rst_clr", 32'(lat_clr), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_lat_d", lat_d, 32'd0);
    end
    rst_n    = 1'b1;
    wr_valid = 1'b0;
    mon_en   = 1'b1;
    repeat (6) @(negedge clk);

    // Directed write
    issue(1'b0, 8'hA5, 1'b0, 1'b0, acc);
    wait_idle();
    chk("a5_latency", last_done_cyc - acc, 5);
    chk("a5_err", 32'(last_err), 32'd0);

    // Clear with simultaneous write request
    issue(1'b1, 8'h5A, 1'b1, 1'b0, acc);
    wait_idle();
    chk("clr_latency", last_done_cyc - acc, 4);
    chk("clr_err", 32'(last_err), 32'd0);

    // Readback stuck at zero
    stuck = 1'b1;
    issue(1'b0, 8'h3C, 1'b0, 1'b0, acc);
    wait_idle();
    chk("mismatch_err", 32'(last_err), 32'd1);
    stuck = 1'b0;
    issue(1'b0, 8'h81, 1'b0, 1'b0, acc);
    wait_idle();
    chk("recover_err", 32'(last_err), 32'd0);

    // Abort during the enable pulse
    issue(1'b0, 8'h99, 1'b0, 1'b0, acc);
    t = 0;
    while (!lat_en && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("abort_reach_pulse", 32'(lat_en), 32'd1);
    rst_n = 1'b0;
    q.delete();
    @(negedge clk);
    chk("abort_en", 32'(lat_en), 32'd0);
    chk("abort_clr", 32'(lat_clr), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort_ready", 32'(wr_ready), 32'd1);

    // Back-to-back with busy-time noise
    issue(1'b0, 8'h01, 1'b0, 1'b0, acc);
    issue(1'b0, 8'hFE, 1'b0, 1'b1, acc2);
    chk("b2b_accept", acc2, last_done_cyc + 1);
    chk("b2b_first_err", 32'(last_err), 32'd0);
    wait_idle();
    chk("b2b_second_err", 32'(last_err), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      wait_idle();
      corrupt = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
      stuck   = ($urandom_range(0, 7) == 0);
      issue($urandom_range(0, 3) == 0, W'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), acc);
    end
    wait_idle();
    corrupt = '0;
    stuck   = 1'b0;
    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
